// File: rtl/pipe_pkg.sv
// Shared pipeline-register constants and EX/MEM payload layout.
package pipe_pkg;

  localparam int unsigned EX_MEM_CTRL_W = 5;
  localparam int unsigned EX_MEM_DATA_W = 105;
  localparam int unsigned MAX_DEPTH     = 8;

  // Control-bit positions inside the ctrl bundle
  localparam int unsigned REGWRITE = 0;
  localparam int unsigned MEMTOREG = 1;
  localparam int unsigned BRANCH   = 2;
  localparam int unsigned MEMREAD  = 3;
  localparam int unsigned MEMWRITE = 4;

  // EX/MEM data field LSB offsets (FlagZero at bit 0, BA at the top)
  localparam int unsigned FLAGZERO_OFF  = 0;
  localparam int unsigned FUNCT3_OFF    = 1;
  localparam int unsigned WR_OFF        = 4;
  localparam int unsigned RD2_OFF       = 9;
  localparam int unsigned ALURESULT_OFF = 41;
  localparam int unsigned BA_OFF        = 73;

  typedef struct packed {
    logic [31:0] ba;
    logic [31:0] alu_result;
    logic [31:0] rd2;
    logic [4:0]  wr;
    logic [2:0]  funct3;
    logic        flag_zero;
  } ex_mem_data_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat carrying a control bundle and a data bundle.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EX_MEM_CTRL_W,
  parameter int unsigned DATA_W = EX_MEM_DATA_W
) ();

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_slot.sv
// One pipeline slot: valid/ctrl/data register with load, clear and squash.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EX_MEM_CTRL_W,
  parameter int unsigned DATA_W = EX_MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  // Squash beats load; an emptied slot keeps its data but never its ctrl
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      ctrl_o  <= '0;
      data_o  <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      ctrl_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      ctrl_o  <= ctrl_i;
      data_o  <= data_i;
    end else if (clear_i) begin
      valid_o <= 1'b0;
      ctrl_o  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: DEPTH slots, bubble collapse, flush, occupancy.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter  int unsigned CTRL_W = EX_MEM_CTRL_W,
  parameter  int unsigned DATA_W = EX_MEM_DATA_W,
  parameter  int unsigned DEPTH  = 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  pipe_stage_reg_if.slave        up,
  pipe_stage_reg_if.master       dn,
  output logic [CNT_W-1:0]       count_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_nxt_c;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              src_valid;
    logic [CTRL_W-1:0] src_ctrl;
    logic [DATA_W-1:0] src_data;
    logic              nxt_accept;
    logic              move;
    logic              accept;
    logic              load;
    logic              clear;

    // Source of this slot: upstream port for slot 0, previous slot otherwise
    if (k == 0) begin : g_head
      assign src_valid = up.valid;
      assign src_ctrl  = up.ctrl;
      assign src_data  = up.data;
    end else begin : g_body
      assign src_valid = valid_q[k-1];
      assign src_ctrl  = ctrl_q[k-1];
      assign src_data  = data_q[k-1];
    end

    // Ready chain runs combinationally from the downstream ready backwards
    if (k == DEPTH - 1) begin : g_tail
      assign nxt_accept = dn.ready;
    end else begin : g_mid
      assign nxt_accept = g_slot[k+1].accept;
    end

    assign move   = valid_q[k] & nxt_accept;
    assign accept = ~valid_q[k] | move;
    assign load   = accept & src_valid;
    assign clear  = move & ~load;

    // Occupancy this slot will have after the edge
    assign valid_nxt_c[k] = ~flush_i & (load | (valid_q[k] & ~clear));

    pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .load_i  (load),
      .clear_i (clear),
      .ctrl_i  (src_ctrl),
      .data_i  (src_data),
      .valid_o (valid_q[k]),
      .ctrl_o  (ctrl_q[k]),
      .data_o  (data_q[k])
    );
  end

  assign up.ready = g_slot[0].accept;
  assign dn.valid = valid_q[DEPTH-1];
  assign dn.ctrl  = ctrl_q[DEPTH-1];
  assign dn.data  = data_q[DEPTH-1];

  // Occupancy count registered alongside the slot valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else begin
      count_o <= CNT_W'($countones(valid_nxt_c));
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg at DEPTH 3, 2 and 1 with a slot-occupancy model.
module tb_pipe_stage_reg;

  localparam int NI = 3;

  typedef struct packed {
    logic              acc;
    logic [7:0]        v;
    logic [7:0][4:0]   c;
    logic [7:0][104:0] d;
  } mstate_t;

  logic clk;
  logic rst_n;

  logic         t_valid [NI];
  logic         t_ready [NI];
  logic         t_flush [NI];
  logic [4:0]   t_ctrl  [NI];
  logic [104:0] t_data  [NI];

  logic         o_valid [NI];
  logic         o_ready [NI];
  logic [4:0]   o_ctrl  [NI];
  logic [104:0] o_data  [NI];
  int           o_count [NI];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q0 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int inst, input string name,
                       input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d %s: got %0h expected %0h", inst, name, act, exp);
    end
  endtask

  // Next slot contents: the tail drains if allowed, each beat steps into an
  // empty slot ahead of it, slot 0 takes the offered beat if it ended up empty.
  function automatic mstate_t step(input mstate_t s, input int dep,
                                   input logic vin, input logic rin, input logic fl,
                                   input logic [4:0] cin, input logic [104:0] din);
    mstate_t n;
    n = s;
    if (n.v[3'(dep-1)] && rin) begin
      n.v[3'(dep-1)] = 1'b0;
      n.c[3'(dep-1)] = '0;
    end
    for (int k = dep - 2; k >= 0; k--) begin
      if (n.v[3'(k)] && !n.v[3'(k+1)]) begin
        n.v[3'(k+1)] = 1'b1;
        n.c[3'(k+1)] = n.c[3'(k)];
        n.d[3'(k+1)] = n.d[3'(k)];
        n.v[3'(k)]   = 1'b0;
        n.c[3'(k)]   = '0;
      end
    end
    n.acc = !n.v[0];
    if (n.acc && vin) begin
      n.v[0] = 1'b1;
      n.c[0] = cin;
      n.d[0] = din;
    end
    if (fl) begin
      n.v = '0;
      n.c = '0;
    end
    return n;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int D = (g == 0) ? 3 : (g == 1) ? 2 : 1;

    pipe_stage_reg_if #(.CTRL_W(5), .DATA_W(105)) u_up ();
    pipe_stage_reg_if #(.CTRL_W(5), .DATA_W(105)) u_dn ();
    logic [$clog2(D+1)-1:0] cnt;
    mstate_t m;
    mstate_t nx;

    assign u_up.valid = t_valid[g];
    assign u_up.ctrl  = t_ctrl[g];
    assign u_up.data  = t_data[g];
    assign u_dn.ready = t_ready[g];
    assign o_valid[g] = u_dn.valid;
    assign o_ctrl[g]  = u_dn.ctrl;
    assign o_data[g]  = u_dn.data;
    assign o_ready[g] = u_up.ready;
    assign o_count[g] = 32'(cnt);

    pipe_stage_reg #(.CTRL_W(5), .DATA_W(105), .DEPTH(D)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (t_flush[g]),
      .up      (u_up.slave),
      .dn      (u_dn.master),
      .count_o (cnt)
    );

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= step(m, D, t_valid[g], t_ready[g], t_flush[g], t_ctrl[g], t_data[g]);
    end

    always @(negedge clk) begin
      nx = step(m, D, t_valid[g], t_ready[g], t_flush[g], t_ctrl[g], t_data[g]);
      check(g, "valid_o", 128'(o_valid[g]), 128'(m.v[D-1]));
      check(g, "ctrl_o",  128'(o_ctrl[g]),  128'(m.c[D-1]));
      check(g, "data_o",  128'(o_data[g]),  128'(m.d[D-1]));
      check(g, "count_o", 128'(o_count[g]), 128'($countones(m.v)));
      check(g, "ready_o", 128'(o_ready[g]), 128'(nx.acc));
      if (g == 0 && rst_n && o_valid[g] && t_ready[g]) q0.push_back(o_data[g][31:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [4:0] c,
                       input logic [104:0] d, input logic r, input logic f);
    t_valid[i] = v;
    t_ctrl[i]  = c;
    t_data[i]  = d;
    t_ready[i] = r;
    t_flush[i] = f;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) drive(i, 1'b0, 5'd0, 105'd0, 1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      check(i, "rst_ready", 128'(o_ready[i]), 128'(1));
      check(i, "rst_count", 128'(o_count[i]), 128'(0));
      check(i, "rst_valid", 128'(o_valid[i]), 128'(0));
    end

    // Streaming through DEPTH=3: two-edge latency, one beat per cycle
    q0.delete();
    for (int n = 1; n <= 10; n++) begin
      drive(0, 1'b1, 5'(n), 105'(n), 1'b1, 1'b0);
      tick();
      if (n < 3) check(0, "stream_lat", 128'(o_valid[0]), 128'(0));
      else       check(0, "stream_data", 128'(o_data[0]), 128'(n - 2));
    end
    drive(0, 1'b0, 5'd0, 105'd0, 1'b1, 1'b0);
    repeat (4) tick();
    check(0, "stream_n", 128'(q0.size()), 128'(10));
    for (int j = 0; j < q0.size(); j++) check(0, "stream_ord", 128'(q0[j]), 128'(j + 1));

    // Back-pressure with a gap: A,_,B then C fills the pipe
    q0.delete();
    drive(0, 1'b1, 5'd1, 105'hA, 1'b0, 1'b0); tick();
    check(0, "bp_cnt_a", 128'(o_count[0]), 128'(1));
    drive(0, 1'b0, 5'd0, 105'd0, 1'b0, 1'b0); tick();
    check(0, "bp_cnt_gap", 128'(o_count[0]), 128'(1));
    drive(0, 1'b1, 5'd2, 105'hB, 1'b0, 1'b0); tick();
    check(0, "bp_cnt_b", 128'(o_count[0]), 128'(2));
    drive(0, 1'b1, 5'd3, 105'hC, 1'b0, 1'b0); tick();
    check(0, "bp_cnt_c", 128'(o_count[0]), 128'(3));
    drive(0, 1'b1, 5'd4, 105'hD, 1'b0, 1'b0); #1;
    check(0, "bp_full_rdy", 128'(o_ready[0]), 128'(0));
    tick();
    check(0, "bp_cnt_hold", 128'(o_count[0]), 128'(3));
    drive(0, 1'b0, 5'd0, 105'd0, 1'b1, 1'b0);
    repeat (5) tick();
    check(0, "bp_n", 128'(q0.size()), 128'(3));
    if (q0.size() == 3) begin
      check(0, "bp_a", 128'(q0[0]), 128'(32'hA));
      check(0, "bp_b", 128'(q0[1]), 128'(32'hB));
      check(0, "bp_c", 128'(q0[2]), 128'(32'hC));
    end

    // Flush of a full DEPTH=2 pipe while a beat is offered
    drive(1, 1'b1, 5'b00011, 105'h11, 1'b0, 1'b0); tick();
    drive(1, 1'b1, 5'b00110, 105'h22, 1'b0, 1'b0); tick();
    check(1, "fl_pre_cnt", 128'(o_count[1]), 128'(2));
    check(1, "fl_pre_ctrl", 128'(o_ctrl[1]), 128'(5'b00011));
    drive(1, 1'b1, 5'b11111, 105'h33, 1'b0, 1'b1); tick();
    drive(1, 1'b0, 5'd0, 105'd0, 1'b0, 1'b0);
    check(1, "fl_cnt", 128'(o_count[1]), 128'(0));
    check(1, "fl_valid", 128'(o_valid[1]), 128'(0));
    check(1, "fl_ctrl", 128'(o_ctrl[1]), 128'(0));
    check(1, "fl_data_hold", 128'(o_data[1]), 128'(105'h11));

    // Bubble with control bits set never reaches the output
    drive(1, 1'b0, 5'b10001, 105'h44, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      tick();
      check(1, "bub_ctrl", 128'(o_ctrl[1]), 128'(0));
      check(1, "bub_valid", 128'(o_valid[1]), 128'(0));
    end
    drive(1, 1'b0, 5'd0, 105'd0, 1'b0, 1'b0);

    // DEPTH=1 full: simultaneous drain and fill
    drive(2, 1'b1, 5'b01010, 105'h58, 1'b0, 1'b0); tick();
    check(2, "sw_x_cnt", 128'(o_count[2]), 128'(1));
    check(2, "sw_x_data", 128'(o_data[2]), 128'(105'h58));
    drive(2, 1'b1, 5'b00101, 105'h59, 1'b1, 1'b0); #1;
    check(2, "sw_rdy", 128'(o_ready[2]), 128'(1));
    tick();
    check(2, "sw_y_data", 128'(o_data[2]), 128'(105'h59));
    check(2, "sw_y_ctrl", 128'(o_ctrl[2]), 128'(5'b00101));
    check(2, "sw_y_cnt", 128'(o_count[2]), 128'(1));
    drive(2, 1'b0, 5'd0, 105'd0, 1'b1, 1'b0); tick();
    check(2, "sw_empty_cnt", 128'(o_count[2]), 128'(0));
    check(2, "sw_empty_ctrl", 128'(o_ctrl[2]), 128'(0));

    // Asynchronous reset with beats in flight
    drive(0, 1'b1, 5'b11011, 105'h77, 1'b0, 1'b0); tick();
    drive(0, 1'b1, 5'b10101, 105'h78, 1'b0, 1'b0); tick();
    check(0, "mr_pre_cnt", 128'(o_count[0]), 128'(2));
    rst_n = 1'b0;
    #1;
    check(0, "mr_valid", 128'(o_valid[0]), 128'(0));
    check(0, "mr_ctrl", 128'(o_ctrl[0]), 128'(0));
    check(0, "mr_data", 128'(o_data[0]), 128'(0));
    check(0, "mr_count", 128'(o_count[0]), 128'(0));
    check(0, "mr_ready", 128'(o_ready[0]), 128'(1));
    drive(0, 1'b0, 5'd0, 105'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register replacing the fixed, always-advancing inter-stage latches between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control-bit bundle and a data bundle through DEPTH register slots with a valid/ready handshake, synchronous flush for branch/hazard squash, bubble collapsing under back-pressure and an occupancy count. Instantiated between each pair of stages; the EX/MEM instance uses DEPTH=1.

## Interface
- CTRL_W, 5, control bundle width (EX/MEM: RegWrite, MemToReg, Branch, MemRead, MemWrite)
- DATA_W, 105, data bundle width (EX/MEM: BA 32, ALUresult 32, rd2 32, wr 5, funct3 3, FlagZero 1)
- DEPTH, 1, number of register slots; legal range 1..8
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous squash of every slot and of the beat offered this cycle
- valid_i  in  1  upstream beat valid
- ready_o  out  1  slot 0 can accept this cycle
- ctrl_i  in  CTRL_W  upstream control bits
- data_i  in  DATA_W  upstream data
- valid_o  out  1  last slot holds a beat
- ready_i  in  1  downstream accepts the last slot this cycle
- ctrl_o  out  CTRL_W  last-slot control bits; all-zero whenever valid_o=0
- data_o  out  DATA_W  last-slot data
- count_o  out  $clog2(DEPTH+1)  number of valid slots

## Operation
- Per slot k: valid[k], ctrl[k], data[k]. Slot DEPTH-1 drives the outputs.
- move[k] = valid[k] & (k==DEPTH-1 ? ready_i : accept[k+1]); accept[k] = ~valid[k] | move[k]; ready_o = accept[0]. The ready chain is combinational from ready_i back to ready_o.
- Slot k loads from slot k-1 (slot 0 from inputs) when accept[k] and the source is valid/moving; a slot that empties without reload clears valid and ctrl.
- Bubble collapsing: an empty slot accepts even when downstream stalls, so gaps close under back-pressure.
- Invariant: ctrl[k]==0 whenever valid[k]==0 (bubbles never write registers or memory). data[k] of an empty slot holds its last value.
- Flush: on an edge with flush_i=1, every valid[k] and ctrl[k] clears; the beat handshaken on valid_i&ready_o that cycle is discarded; a downstream handshake that cycle still completes. Flush overrides every move and load.
- count_o is the popcount of valid[], registered with them.
- Reset (rst_n=0, asynchronous): all valid, ctrl and data clear to 0; valid_o=0, ctrl_o=0, data_o=0, count_o=0; ready_o=1 (combinational from empty slots) once reset is applied. Reset mid-transfer drops all in-flight beats.

## Timing
- Latency: a beat accepted at edge N appears on valid_o after edge N+DEPTH-1 (DEPTH=1: output visible after the accepting edge), with no back-pressure.
- Throughput: one beat per cycle sustained when ready_i=1.
- ready_i=0 with full pipe: ready_o=0 same cycle; no beat lost or duplicated.
- Simultaneous ready_i=1 and valid_i=1 on a full pipe: shift all slots, accept new beat, count_o unchanged.
- Outputs are register-driven except ready_o.

## Structure
- Shared package pipe_pkg: EX_MEM_CTRL_W/EX_MEM_DATA_W constants, control-bit index constants (REGWRITE=0, MEMTOREG=1, BRANCH=2, MEMREAD=3, MEMWRITE=4) and data field offsets, reused by all stage instances.
- One sub-module pipe_slot (valid/ctrl/data register with load, clear, flush, async reset), generated DEPTH times; top holds the ready chain and counter.

## Test plan
- Reset: DEPTH=3, drive rst_n=0 mid-stream -> valid_o=0, ctrl_o=0, data_o=0, count_o=0, ready_o=1 immediately.
- Streaming: DEPTH=3, ready_i=1, data 1..10 each cycle -> data_o 1..10 in order, first after 2 edges, one per cycle.
- Back-pressure/collapse: DEPTH=3, beats A,_,B with ready_i=0 -> count_o reaches 2 then 3 with C, ready_o=0 at full; release -> A,B,C out in order, no loss.
- Flush: DEPTH=2 holding 2 beats, flush_i=1 with valid_i=1 ctrl=5'b11111 -> next cycle count_o=0, valid_o=0, ctrl_o=0.
- Bubble ctrl: valid_i=0 with ctrl_i=5'b10001 -> ctrl_o stays 0.
- Full-pipe swap: DEPTH=1 full with X, valid_i=1 Y, ready_i=1 -> X consumed, data_o=Y next cycle, count_o=1.
